// File: rtl/hsid_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hsid_fifo_ctrl_pkg
// Shared types and constants for the HSID reference-vector FIFO sequencer.
// Revision: 1.0
// ============================================================================
package hsid_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } hsid_fifo_ctrl_state_t;

  localparam int SKID_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/hsid_skid_buf.sv
`default_nettype none
// ============================================================================
// hsid_skid_buf
// Two-entry ready/valid buffer carrying {pixel_last, band_last, data}.
// Revision: 1.0
// ============================================================================
module hsid_skid_buf
  import hsid_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/hsid_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// hsid_fifo_ctrl
// Loads a reference spectral vector into an hsid_fifo and replays it per pixel.
// Revision: 1.0
// ============================================================================
module hsid_fifo_ctrl
  import hsid_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PIXELS_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FIFO_ADDR_WIDTH:0] num_bands,
  input  logic [PIXELS_WIDTH-1:0]  num_pixels,
  input  logic                     ref_valid,
  input  logic [DATA_WIDTH-1:0]    ref_data,
  output logic                     ref_ready,
  output logic                     fifo_wr_en,
  output logic                     fifo_rd_en,
  output logic                     fifo_loop_en,
  output logic                     fifo_clear,
  output logic [DATA_WIDTH-1:0]    fifo_data_in,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic [DATA_WIDTH-1:0]    fifo_data_out,
  output logic                     band_valid,
  output logic [DATA_WIDTH-1:0]    band_data,
  output logic                     band_last,
  output logic                     pixel_last,
  input  logic                     band_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int BW = FIFO_ADDR_WIDTH + 1;
  localparam logic [BW-1:0] c_fifo_depth = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

  hsid_fifo_ctrl_state_t   r_state;
  logic                    r_from_abort;
  logic                    r_error;
  logic                    r_issue_done;
  logic                    r_inflight;
  logic [1:0]              r_inflight_tag;
  logic [BW-1:0]           r_nb;
  logic [BW-1:0]           r_load_cnt;
  logic [BW-1:0]           r_band_cnt;
  logic [PIXELS_WIDTH-1:0] r_np;
  logic [PIXELS_WIDTH-1:0] r_pix_cnt;

  logic                    w_skid_valid;
  logic [DATA_WIDTH+1:0]   w_skid_head;
  logic [1:0]              w_skid_count;
  logic                    w_pop;
  logic [2:0]              w_occ_next;
  logic                    w_room;
  logic                    w_tag_band_last;
  logic                    w_tag_pixel_last;
  logic                    w_issue;
  logic                    w_start_bad;

  assign w_pop = w_skid_valid && band_ready;

  // Credit check: whatever remains buffered after this cycle plus the sample
  // already returning must leave room for one more return.
  assign w_occ_next = {1'b0, w_skid_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_room     = (w_occ_next < 3'd2);

  assign w_tag_band_last  = (r_band_cnt == r_nb - BW'(1));
  assign w_tag_pixel_last = w_tag_band_last && (r_pix_cnt == r_np - PIXELS_WIDTH'(1));

  assign w_issue = (r_state == STREAM) && !abort && !r_issue_done && !fifo_empty && w_room;

  assign w_start_bad = (num_bands == '0) || (num_bands > c_fifo_depth);

  assign ref_ready    = (r_state == LOAD) && !abort && !fifo_full && (r_load_cnt < r_nb);
  assign fifo_wr_en   = ref_valid && ref_ready;
  assign fifo_rd_en   = 1'b0;
  assign fifo_loop_en = w_issue;
  assign fifo_data_in = ref_data;
  assign fifo_clear   = (r_state == CLEAR) || (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign error        = r_error;

  assign band_valid = w_skid_valid;
  assign {pixel_last, band_last, band_data} = w_skid_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_from_abort   <= 1'b0;
      r_error        <= 1'b0;
      r_issue_done   <= 1'b0;
      r_inflight     <= 1'b0;
      r_inflight_tag <= 2'b00;
      r_nb           <= '0;
      r_load_cnt     <= '0;
      r_band_cnt     <= '0;
      r_np           <= '0;
      r_pix_cnt      <= '0;
    end else begin
      r_inflight     <= w_issue;
      r_inflight_tag <= {w_tag_pixel_last, w_tag_band_last};

      if (abort) begin
        r_state      <= CLEAR;
        r_from_abort <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_start_bad) begin
                r_error <= 1'b1;
              end else begin
                r_error      <= 1'b0;
                r_nb         <= num_bands;
                r_np         <= num_pixels;
                r_load_cnt   <= '0;
                r_band_cnt   <= '0;
                r_pix_cnt    <= '0;
                r_issue_done <= 1'b0;
                r_from_abort <= 1'b0;
                r_state      <= CLEAR;
              end
            end
          end
          CLEAR: begin
            r_state      <= r_from_abort ? IDLE : LOAD;
            r_from_abort <= 1'b0;
          end
          LOAD: begin
            if (fifo_wr_en) begin
              r_load_cnt <= r_load_cnt + BW'(1);
              if ((r_load_cnt + BW'(1)) == r_nb) begin
                r_state <= (r_np == '0) ? DONE : STREAM;
              end
            end
          end
          STREAM: begin
            if (w_issue) begin
              if (w_tag_band_last) begin
                r_band_cnt <= '0;
                if (w_tag_pixel_last) begin
                  r_issue_done <= 1'b1;
                end else begin
                  r_pix_cnt <= r_pix_cnt + PIXELS_WIDTH'(1);
                end
              end else begin
                r_band_cnt <= r_band_cnt + BW'(1);
              end
            end
            if (w_pop && pixel_last) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  hsid_skid_buf #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (r_inflight),
    .push_data ({r_inflight_tag, fifo_data_out}),
    .pop       (band_ready),
    .out_valid (w_skid_valid),
    .out_data  (w_skid_head),
    .count     (w_skid_count)
  );

endmodule
`default_nettype wire

// File: doc/hsid_fifo_ctrl.md
Name: hsid_fifo_ctrl

Overview:
Sequencer for one hsid_fifo instance in the HSID distance datapath.
- Clears the FIFO, then loads a reference spectral vector of num_bands samples from an upstream stream.
- Replays the vector num_pixels times using the FIFO loop mode, feeding the distance pipeline through a ready/valid band stream.
- Pulses done and clears the FIFO when finished.

Parameters:
DATA_WIDTH, 16, band sample width; matches the FIFO.
FIFO_ADDR_WIDTH, 4, FIFO address width; FIFO_DEPTH = 2**FIFO_ADDR_WIDTH.
PIXELS_WIDTH, 16, width of the pixel count.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  synchronous abort; any state -> CLEAR -> IDLE.
num_bands  in  FIFO_ADDR_WIDTH+1  vector length, legal range 1..FIFO_DEPTH; latched on start.
num_pixels  in  PIXELS_WIDTH  replay count; latched on start.
ref_valid  in  1  upstream reference sample valid.
ref_data  in  DATA_WIDTH  reference sample.
ref_ready  out  1  upstream ready.
fifo_wr_en, fifo_rd_en, fifo_loop_en, fifo_clear  out  1  FIFO controls.
fifo_data_in  out  DATA_WIDTH  FIFO write data (= ref_data).
fifo_full, fifo_empty  in  1  FIFO status.
fifo_data_out  in  DATA_WIDTH  FIFO read data; valid 1 cycle after loop_en.
band_valid  out  1  downstream sample valid.
band_data  out  DATA_WIDTH  downstream sample.
band_last  out  1  last band of the current pixel.
pixel_last  out  1  last band of the last pixel.
band_ready  in  1  downstream ready.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at run end.
error  out  1  sticky illegal-config flag; cleared by the next legal start.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, skid buffer empty.
- State IDLE:
  - On start with num_bands==0 or num_bands>FIFO_DEPTH: set error, remain in IDLE.
  - Otherwise: latch the config, clear error, go to CLEAR.
- State CLEAR: fifo_clear=1 for exactly one cycle, then LOAD. If entered from abort, go to IDLE instead.
- State LOAD:
  - ref_ready = !fifo_full && load_cnt<num_bands.
  - fifo_wr_en = ref_valid && ref_ready; load_cnt increments on each write.
  - When load_cnt reaches num_bands: go to STREAM, or to DONE if num_pixels==0.
- State STREAM:
  - fifo_loop_en is issued when (skid_occ + inflight - (band_valid && band_ready)) < 2 and issued < num_bands*num_pixels.
  - fifo_rd_en is never asserted in STREAM, so the FIFO count stays at num_bands.
  - Returned data enters a 2-entry skid buffer on the cycle after loop_en.
  - Sustains 1 band/cycle while band_ready=1. With band_ready=0 it holds band_data stable and issues nothing further.
  - band_last is tagged when the issue band counter == num_bands-1; pixel_last is also tagged when the pixel counter == num_pixels-1.
  - When the final band handshakes (band_valid && band_ready && pixel_last): go to DONE.
- State DONE: fifo_clear=1 and done=1 for one cycle, then IDLE.
- Counter widths: band counter FIFO_ADDR_WIDTH+1 bits; pixel counter PIXELS_WIDTH bits; both wrap/reset at their limits, with no overflow.
- abort:
  - Flushes the skid buffer (band_valid=0 next cycle) and drops ref_ready.
  - Discards in-flight data.
  - No done pulse.
- start while busy is ignored.
- Asynchronous reset mid-run: immediate return to reset values. The FIFO is reset independently.
- Band order within each pixel equals load order; this holds because loop mode rewrites each head sample to the tail.

Decomposition:
- Package hsid_fifo_ctrl_pkg holds:
  - state enum hsid_fifo_ctrl_state_t {IDLE, CLEAR, LOAD, STREAM, DONE};
  - SKID_DEPTH=2.
- One sub-module: hsid_skid_buf, a 2-entry ready/valid buffer carrying {pixel_last, band_last, data}.

Test Plan:
1. num_bands=4, num_pixels=3, data 0x11,0x22,0x33,0x44, band_ready=1 -> 12 bands in order 11,22,33,44 x3 with no gaps; band_last on every 4th band; pixel_last on the 12th; done pulse; fifo_clear asserted in CLEAR and DONE.
2. num_bands=16 (full FIFO), num_pixels=2, upstream holds ref_valid for 20 cycles -> ref_ready drops after 16 writes; 32 bands out; no extra writes.
3. Same as scenario 1 with band_ready toggling 1,0,0,1 -> no loss or duplication; band_data stable while stalled; skid occupancy never exceeds 2.
4. num_bands=0, then num_bands=17 -> error=1, busy stays 0; a following legal start clears error.
5. abort on the 5th band of scenario 1 -> band_valid=0 next cycle, one fifo_clear cycle, IDLE, no done pulse.
6. num_pixels=0 and num_bands=3 -> load of 3 samples, then DONE; zero bands out; done pulse. Async rst mid-LOAD -> all outputs 0 immediately.
